// File: rtl/swivm_membus_pkg.sv
// swivm_membus shared definitions: command, size and error codes,
// FSM states and alignment helpers.
package swivm_membus_pkg;

  localparam logic [3:0] MMU_READ  = 4'h1;
  localparam logic [3:0] MMU_WRITE = 4'h2;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_HALF2 = 2'b10;
  localparam logic [1:0] SZ_WORD  = 2'b11;

  localparam logic [3:0] ERR_NONE  = 4'd0;
  localparam logic [3:0] ERR_ALIGN = 4'd1;
  localparam logic [3:0] ERR_RANGE = 4'd2;
  localparam logic [3:0] ERR_CMD   = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RDWAIT = 3'd2,
    S_WR     = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  function automatic logic is_half(input logic [1:0] s);
    return (s == SZ_HALF) || (s == SZ_HALF2);
  endfunction

  function automatic logic misaligned(
    input logic [1:0] s,
    input logic [1:0] a
  );
    logic m;
    m = 1'b0;
    if (is_half(s) && a[0]) m = 1'b1;
    if ((s == SZ_WORD) && (a != 2'b00)) m = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/swivm_membus_lanes.sv
// Byte/half lane extraction and store merge against a 32-bit RAM word.
// Purely combinational; little-endian lane order.
module swivm_membus_lanes
  import swivm_membus_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rd_o,
  output logic [31:0] merged_o
);

  logic [4:0] bsh;
  logic [4:0] hsh;

  assign bsh = {lane_i, 3'b000};
  assign hsh = {lane_i[1], 4'b0000};

  always_comb begin
    rd_o     = '0;
    merged_o = word_i;
    unique case (1'b1)
      (size_i == SZ_WORD): begin
        rd_o     = word_i;
        merged_o = wdata_i;
      end
      (size_i == SZ_BYTE): begin
        rd_o[7:0]          = word_i[bsh +: 8];
        merged_o[bsh +: 8] = wdata_i[7:0];
      end
      default: begin
        rd_o[15:0]          = word_i[hsh +: 16];
        merged_o[hsh +: 16] = wdata_i[15:0];
      end
    endcase
  end

endmodule

// File: rtl/swivm_membus.sv
// Physical memory access unit: one request at a time against a word RAM,
// with sub-word read-modify-write, alignment and range checking.
module swivm_membus
  import swivm_membus_pkg::*;
#(
  parameter  int MEM_BYTES = 65536,
  localparam int MEM_AW    = $clog2(MEM_BYTES) - 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wrdata,
  input  logic [1:0]        i_size,
  input  logic [3:0]        i_cmd,
  input  logic              i_valid,
  output logic [31:0]       o_rddata,
  output logic              o_rddata_valid,
  output logic [3:0]        o_error,
  output logic              o_busy,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  state_e            state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [1:0]        size_q, size_d;
  logic              wr_q, wr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rddata_q, rddata_d;
  logic [3:0]        err_q, err_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [MEM_AW-1:0] maddr_q, maddr_d;
  logic [31:0]       mwdata_q, mwdata_d;

  logic [31:0] lane_rd;
  logic [31:0] lane_merged;
  logic        cmd_ok;
  logic        oor;

  swivm_membus_lanes u_lanes (
    .word_i   (i_mem_rdata),
    .lane_i   (lane_q),
    .size_i   (size_q),
    .wdata_i  (wdata_q),
    .rd_o     (lane_rd),
    .merged_o (lane_merged)
  );

  assign cmd_ok = (i_cmd == MMU_READ) || (i_cmd == MMU_WRITE);
  assign oor    = i_addr >= 32'(MEM_BYTES);

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    size_d   = size_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    rddata_d = rddata_q;
    err_d    = err_q;
    en_d     = 1'b0;
    we_d     = 1'b0;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          lane_d   = i_addr[1:0];
          size_d   = i_size;
          wr_d     = (i_cmd == MMU_WRITE);
          wdata_d  = i_wrdata;
          rddata_d = '0;
          err_d    = ERR_NONE;
          state_d  = S_RESP;
          if (!cmd_ok) begin
            err_d = ERR_CMD;
          end else if (misaligned(i_size, i_addr[1:0])) begin
            err_d = ERR_ALIGN;
          end else if (oor) begin
            err_d = ERR_RANGE;
          end else begin
            // full-word stores skip the read; everything else reads first
            en_d    = 1'b1;
            maddr_d = i_addr[MEM_AW+1:2];
            if ((i_cmd == MMU_WRITE) && (i_size == SZ_WORD)) begin
              we_d     = 1'b1;
              mwdata_d = i_wrdata;
              state_d  = S_WR;
            end else begin
              state_d = S_RD;
            end
          end
        end
      end
      S_RD: begin
        state_d = S_RDWAIT;
      end
      S_RDWAIT: begin
        if (wr_q) begin
          en_d     = 1'b1;
          we_d     = 1'b1;
          mwdata_d = lane_merged;
          state_d  = S_WR;
        end else begin
          rddata_d = lane_rd;
          state_d  = S_RESP;
        end
      end
      S_WR: begin
        rddata_d = '0;
        state_d  = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      lane_q   <= '0;
      size_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      rddata_q <= '0;
      err_q    <= ERR_NONE;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      size_q   <= size_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      rddata_q <= rddata_d;
      err_q    <= err_d;
      en_q     <= en_d;
      we_q     <= we_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  assign o_rddata       = rddata_q;
  assign o_rddata_valid = (state_q == S_RESP);
  assign o_error        = (state_q == S_RESP) ? err_q : ERR_NONE;
  assign o_busy         = (state_q != S_IDLE);
  assign o_mem_addr     = maddr_q;
  assign o_mem_en       = en_q;
  assign o_mem_we       = we_q;
  assign o_mem_wdata    = mwdata_q;

endmodule
